// File: rtl/tff_bank_sequencer.sv
// Command-driven sequencer for a bank of SR-core T flip-flops: masked toggle,
// load, clear and multi-step up/down counting over a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a command, t = 0
// EXEC    | single-cycle toggle/load/clear, t derived from latched arg
// RUN     | counting; one step per edge while en = 1, step_cnt counts down
// DONE    | one-cycle completion pulse, t = 0, not ready
module tff_bank_sequencer #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_arg,
  input  logic          en,
  output logic [N-1:0]  q,
  output logic [N-1:0]  qb,
  output logic [N-1:0]  s_out,
  output logic [N-1:0]  r_out,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_TOGGLE = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_UP     = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [N-1:0]  mask_q;
  logic [CW-1:0] step_cnt;
  logic [N-1:0]  t;

  // T vector: the only path by which the bank changes
  always_comb begin
    t = '0;
    case (state)
      ST_EXEC: begin
        case (op_q)
          OP_TOGGLE: t = mask_q;
          OP_LOAD:   t = q ^ mask_q;
          OP_CLEAR:  t = q;
          default:   t = '0;
        endcase
      end
      ST_RUN: begin
        if (en) begin
          t[0] = 1'b1;
          for (int i = 1; i < N; i++) begin
            if (op_q == OP_DOWN) t[i] = t[i-1] & ~q[i-1];
            else                 t[i] = t[i-1] &  q[i-1];
          end
        end
      end
      default: t = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      q        <= '0;
      op_q     <= OP_NOP;
      mask_q   <= '0;
      step_cnt <= '0;
    end else begin
      q <= q ^ t;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            mask_q   <= cmd_arg[N-1:0];
            step_cnt <= cmd_arg;
            case (cmd_op)
              OP_TOGGLE, OP_LOAD, OP_CLEAR: state <= ST_EXEC;
              OP_UP, OP_DOWN: state <= (cmd_arg == '0) ? ST_DONE : ST_RUN;
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_EXEC: state <= ST_DONE;
        ST_RUN: begin
          if (en) begin
            step_cnt <= step_cnt - CW'(1);
            if (step_cnt == CW'(1)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign qb        = ~q;
  assign s_out     = t & ~q;
  assign r_out     = t & q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Randomized scoreboard bench for tff_bank_sequencer: a driver pushes the
// expected outcome of each command, a monitor checks what the DUT presents.
module tb_tff_bank_sequencer;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int MASK = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_arg;
  logic          en;
  logic [N-1:0]  q, qb, s_out, r_out;
  logic          busy, done;

  always #5 clk = ~clk;

  tff_bank_sequencer #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .en(en), .q(q), .qb(qb),
    .s_out(s_out), .r_out(r_out), .busy(busy), .done(done)
  );

  typedef struct {
    int op;
    int arg;
    int start;
    int fin;
  } cmd_t;

  cmd_t sb[$];
  int   model_q = 0;
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int step_val(input int op, input int v);
    return (op == 3) ? ((v + 1) & MASK) : ((v - 1) & MASK);
  endfunction

  function automatic int model_fin(input int op, input int arg, input int qv);
    case (op)
      1: return qv ^ (arg & MASK);
      2: return arg & MASK;
      3: return (qv + arg) % (1 << N);
      4: return ((qv - arg) % (1 << N) + (1 << N)) % (1 << N);
      5: return 0;
      default: return qv;
    endcase
  endfunction

  function automatic bit is_exec(input int op);
    return (op == 1) || (op == 2) || (op == 5);
  endfunction

  function automatic bit is_count(input int op, input int arg);
    return ((op == 3) || (op == 4)) && (arg > 0);
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    bit   active = 0;
    bit   prev_done = 0;
    bit   ready_prev = 0;
    cmd_t cur;
    int   elapsed = 0, steps = 0, prev_q = 0, exp_q, t_exp, qi;
    forever begin
      @(posedge clk);
      #1;
      qi = int'(q);
      if (!rst_n) begin
        chk("reset_q", q, 0);
        chk("reset_qb", qb, MASK);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", cmd_ready, 1);
        sb.delete();
        active = 0; prev_q = 0; prev_done = 0; ready_prev = 1;
        continue;
      end
      chk("qb_is_not_q", qb, (~qi) & MASK);
      chk("s_and_r_zero", s_out & r_out, 0);
      chk("done_single_cycle", prev_done & done, 0);
      if (ready_prev && cmd_valid) begin
        if (sb.size() == 0) begin
          chk("accept_without_issue", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          active = 1; elapsed = 0; steps = 0;
          chk("q_at_accept", q, cur.start);
          chk("busy_after_accept", busy, 1);
          chk("ready_after_accept", cmd_ready, 0);
          if (is_exec(cur.op)) begin
            t_exp = cur.start ^ cur.fin;
            chk("exec_done_low", done, 0);
            chk("exec_s_out", s_out, t_exp & ~cur.start & MASK);
            chk("exec_r_out", r_out, t_exp & cur.start);
          end else if (is_count(cur.op, cur.arg)) begin
            chk("run_done_low", done, 0);
            t_exp = en ? (step_val(cur.op, qi) ^ qi) : 0;
            chk("run_s_out", s_out, t_exp & ~qi & MASK);
            chk("run_r_out", r_out, t_exp & qi);
          end else begin
            chk("nop_done", done, 1);
            active = 0;
          end
        end
      end else if (active) begin
        elapsed++;
        if (is_exec(cur.op)) begin
          chk("exec_done", done, 1);
          chk("exec_q_final", q, cur.fin);
          chk("exec_busy_in_done", busy, 1);
          chk("exec_ready_in_done", cmd_ready, 0);
          active = 0;
        end else begin
          exp_q = en ? step_val(cur.op, prev_q) : prev_q;
          if (en) steps++;
          chk("run_q_step", q, exp_q);
          chk("run_done_timing", done, (steps == cur.arg) ? 1 : 0);
          if (steps >= cur.arg) begin
            chk("run_q_final", q, cur.fin);
            chk("run_busy_in_done", busy, 1);
            chk("run_ready_in_done", cmd_ready, 0);
            active = 0;
          end else begin
            t_exp = en ? (step_val(cur.op, qi) ^ qi) : 0;
            chk("run_s_out", s_out, t_exp & ~qi & MASK);
            chk("run_r_out", r_out, t_exp & qi);
            if (elapsed > 2000) begin
              chk("run_timeout", elapsed, 0);
              active = 0;
            end
          end
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_q", q, prev_q);
      end
      ready_prev = cmd_ready;
      prev_q = qi;
      prev_done = done;
    end
  end

  // en_mode: 0 = en held high, 1 = random en, 2 = one step then 3-cycle gap
  task automatic issue(input int op, input int arg, input int en_mode,
                       input bit hold, input bit wait_done);
    int   k;
    cmd_t c;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    cmd_op    = op[2:0];
    cmd_arg   = arg[CW-1:0];
    cmd_valid = 1'b1;
    en        = (en_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    c.op    = op;
    c.arg   = arg & ((1 << CW) - 1);
    c.start = model_q;
    c.fin   = model_fin(op, c.arg, model_q);
    sb.push_back(c);
    model_q = c.fin;
    @(negedge clk);
    if (hold) begin
      cmd_op  = 3'($urandom_range(0, 7));
      cmd_arg = CW'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    if (!wait_done) return;
    k = 0;
    while (!done) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 3) != 0);
        default: en = (k == 0) || (k >= 4);
      endcase
      @(negedge clk);
      k++;
      if (k > 1200) begin
        compared++;
        mismatched++;
        $display("FAIL drv_done_timeout: got no done after %0d cycles, expected done", k);
        break;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin : driver
    int op, arg;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_q = 0;

    issue(1, 'b1010, 0, 0, 1);   // toggle from 0000
    issue(1, 'b1010, 0, 0, 1);   // toggle back
    issue(2, 'b0110, 0, 0, 1);
    issue(2, 'b1100, 0, 0, 1);
    issue(5, 0, 0, 0, 1);
    issue(2, 'b1110, 0, 0, 1);
    issue(3, 3, 0, 0, 1);        // 1111, 0000, 0001
    issue(2, 'b0001, 0, 0, 1);
    issue(4, 2, 2, 0, 1);        // step, 3-cycle gap, step
    issue(3, 0, 0, 0, 1);        // zero-length count
    issue(7, 'hff, 0, 0, 1);     // reserved op
    issue(6, 'h0f, 0, 0, 1);
    issue(3, 5, 0, 1, 1);        // cmd_valid held high while busy
    issue(2, 'h3f, 0, 1, 1);

    issue(3, 50, 0, 0, 0);       // abort a long count with reset
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_q = 0;

    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 7);
      arg = ((op == 3) || (op == 4)) ? $urandom_range(0, 20) : $urandom_range(0, 255);
      issue(op, arg, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
